// File: rtl/arm_mc_control_if.sv
// Unified instruction/data memory handshake between the multicycle control unit and the memory wrapper.
interface arm_mc_control_if;
  logic MemReq;
  logic MemWrite;
  logic MemReady;

  modport master (output MemReq, output MemWrite, input MemReady);
  modport slave  (input MemReq, input MemWrite, output MemReady);
endinterface

// File: rtl/arm_mc_control.sv
// Multicycle ARM-subset control FSM: shared memory port with wait timeout,
// registered condition flags and a sticky fault state.
module arm_mc_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  arm_mc_control_if.master mem,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [3:0]  Flags,
  output logic        Busy,
  output logic        Fault
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXECUTER, EXECUTEI, ALUWB,
    MEMADR, MEMREAD, MEMWB, MEMWRITE, BRANCH, FAULT
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       adr_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] alu_control;
  } ctrl_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [3:0] CMD_CMP = 4'b1010;

  localparam bit               TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t           state, state_n;
  ctrl_t            c;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       alu_op;
  logic             cond_ex, expire, flag_upd;

  logic [1:0] op;
  logic       funct_i, s_bit;
  logic [3:0] cmd, cond;
  assign op      = Instr[27:26];
  assign funct_i = Instr[25];
  assign cmd     = Instr[24:21];
  assign s_bit   = Instr[20];
  assign cond    = Instr[31:28];

  wire unused_instr = ^Instr[19:0];

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};

  always_comb begin
    unique case (cmd)
      4'b0010, CMD_CMP: alu_op = ALU_SUB;
      4'b0000:          alu_op = ALU_AND;
      4'b1100:          alu_op = ALU_ORR;
      default:          alu_op = ALU_ADD;
    endcase
  end

  // Flags packed as {N,Z,C,V}
  always_comb begin
    unique case (cond)
      4'b0000: cond_ex = Flags[2];
      4'b0001: cond_ex = ~Flags[2];
      4'b0010: cond_ex = Flags[1];
      4'b0011: cond_ex = ~Flags[1];
      4'b0100: cond_ex = Flags[3];
      4'b0101: cond_ex = ~Flags[3];
      4'b0110: cond_ex = Flags[0];
      4'b0111: cond_ex = ~Flags[0];
      4'b1000: cond_ex = Flags[1] & ~Flags[2];
      4'b1001: cond_ex = ~Flags[1] | Flags[2];
      4'b1010: cond_ex = (Flags[3] == Flags[0]);
      4'b1011: cond_ex = (Flags[3] != Flags[0]);
      4'b1100: cond_ex = ~Flags[2] & (Flags[3] == Flags[0]);
      4'b1101: cond_ex = Flags[2] | (Flags[3] != Flags[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    state_n = state;
    c       = '0;
    unique case (state)
      FETCH: begin
        c.mem_req    = 1'b1;
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        if (mem.MemReady) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_n    = DECODE;
        end
      end
      DECODE: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        if (!cond_ex) state_n = FETCH;
        else begin
          unique case (op)
            2'b00:   state_n = funct_i ? EXECUTEI : EXECUTER;
            2'b01:   state_n = MEMADR;
            2'b10:   state_n = BRANCH;
            default: state_n = FETCH;
          endcase
        end
      end
      EXECUTER: begin
        c.alu_control = alu_op;
        state_n       = ALUWB;
      end
      EXECUTEI: begin
        c.alu_src_b   = 2'b01;
        c.alu_control = alu_op;
        state_n       = ALUWB;
      end
      ALUWB: begin
        c.reg_write = (cmd != CMD_CMP);
        state_n     = FETCH;
      end
      MEMADR: begin
        c.alu_src_b = 2'b01;
        state_n     = s_bit ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        c.mem_req = 1'b1;
        c.adr_src = 1'b1;
        if (mem.MemReady) state_n = MEMWB;
      end
      MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
        state_n      = FETCH;
      end
      MEMWRITE: begin
        c.mem_req   = 1'b1;
        c.mem_write = 1'b1;
        c.adr_src   = 1'b1;
        if (mem.MemReady) state_n = FETCH;
      end
      BRANCH: begin
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        c.pc_write   = 1'b1;
        state_n      = FETCH;
      end
      default: state_n = FAULT;
    endcase
    // expire already requires MemReady low, so a same-cycle completion wins
    if (expire) state_n = FAULT;
  end

  assign expire = TO_EN && c.mem_req && !mem.MemReady && (cnt == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (state_n != state || mem.MemReady || !c.mem_req) cnt <= '0;
      else                                                cnt <= cnt + CNT_W'(1);
    end
  end

  assign flag_upd = (state == EXECUTER || state == EXECUTEI) && (s_bit || cmd == CMD_CMP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) Flags <= 4'b0000;
    else if (flag_upd) begin
      if (alu_op == ALU_AND || alu_op == ALU_ORR) Flags[3:2] <= ALUFlags[3:2];
      else                                        Flags      <= ALUFlags;
    end
  end

  // Controls are gated by reset so an abort mid-request drops them immediately
  assign mem.MemReq   = reset & c.mem_req;
  assign mem.MemWrite = reset & c.mem_write;
  assign IRWrite      = reset & c.ir_write;
  assign PCWrite      = reset & c.pc_write;
  assign RegWrite     = reset & c.reg_write;
  assign AdrSrc       = reset & c.adr_src;
  assign ALUSrcA      = reset & c.alu_src_a;
  assign ALUSrcB      = reset ? c.alu_src_b   : 2'b00;
  assign ResultSrc    = reset ? c.result_src  : 2'b00;
  assign ALUControl   = reset ? c.alu_control : 3'b000;

  assign Busy  = (state != FAULT);
  assign Fault = (state == FAULT);

endmodule

// File: tb/tb_arm_mc_control.sv
// Directed bench for arm_mc_control with TIMEOUT=4.
module tb_arm_mc_control;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        IRWrite, PCWrite, RegWrite, AdrSrc, ALUSrcA, Busy, Fault;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc;
  logic [2:0]  ALUControl;
  logic [3:0]  Flags;
  int total = 0;
  int bad   = 0;

  arm_mc_control_if mif ();

  arm_mc_control #(.TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .mem(mif), .Instr(Instr), .ALUFlags(ALUFlags),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags), .Busy(Busy), .Fault(Fault)
  );

  always #5 clk = ~clk;

  // {MemReq,MemWrite,IRWrite,PCWrite,RegWrite,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUControl}
  logic [13:0] ctl;
  assign ctl = {mif.MemReq, mif.MemWrite, IRWrite, PCWrite, RegWrite, AdrSrc, ALUSrcA,
                ALUSrcB, ResultSrc, ALUControl};

  localparam logic [13:0] F_W    = 14'b1_0_0_0_0_0_1_10_10_000;
  localparam logic [13:0] F_R    = 14'b1_0_1_1_0_0_1_10_10_000;
  localparam logic [13:0] DEC    = 14'b0_0_0_0_0_0_1_10_00_000;
  localparam logic [13:0] EXI_AD = 14'b0_0_0_0_0_0_0_01_00_000;
  localparam logic [13:0] EXI_AN = 14'b0_0_0_0_0_0_0_01_00_010;
  localparam logic [13:0] EXR_SB = 14'b0_0_0_0_0_0_0_00_00_001;
  localparam logic [13:0] EXR_AD = 14'b0_0_0_0_0_0_0_00_00_000;
  localparam logic [13:0] WB_RW  = 14'b0_0_0_0_1_0_0_00_00_000;
  localparam logic [13:0] MADR   = 14'b0_0_0_0_0_0_0_01_00_000;
  localparam logic [13:0] MRD    = 14'b1_0_0_0_0_1_0_00_00_000;
  localparam logic [13:0] MWB    = 14'b0_0_0_0_1_0_0_00_01_000;
  localparam logic [13:0] MWR    = 14'b1_1_0_0_0_1_0_00_00_000;
  localparam logic [13:0] BR     = 14'b0_0_0_1_0_0_0_01_10_000;
  localparam logic [13:0] IDLE   = 14'b0;

  localparam logic [31:0] ADDI = 32'hE2821005;
  localparam logic [31:0] SUBS = 32'hE0500000;
  localparam logic [31:0] ADDS = 32'hE0900000;
  localparam logic [31:0] BEQ  = 32'h0A000002;
  localparam logic [31:0] LDR  = 32'hE5923008;
  localparam logic [31:0] STR  = 32'hE5821004;
  localparam logic [31:0] CMP  = 32'hE1520003;
  localparam logic [31:0] ANDS = 32'hE2111000;

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; Instr = 32'h0; ALUFlags = 4'h0; mif.MemReady = 1'b0;
    #2;
    total++; if (ctl !== IDLE) begin bad++; $display("FAIL rst_ctl got=%b exp=%b", ctl, IDLE); end
    total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL rst_flags got=%b exp=0000", Flags); end
    total++; if (Fault !== 1'b0) begin bad++; $display("FAIL rst_fault got=%b exp=0", Fault); end
    nxt(); nxt();
    reset = 1'b1; #1;
    total++; if (ctl !== F_W) begin bad++; $display("FAIL rst_fetch got=%b exp=%b", ctl, F_W); end
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL rst_busy got=%b exp=1", Busy); end
  endtask

  task automatic test_fetch_add();
    Instr = ADDI; mif.MemReady = 1'b0; #1;
    total++; if (ctl !== F_W) begin bad++; $display("FAIL add_f1 got=%b exp=%b", ctl, F_W); end
    nxt(); #1;
    total++; if (ctl !== F_W) begin bad++; $display("FAIL add_f2 got=%b exp=%b", ctl, F_W); end
    nxt(); mif.MemReady = 1'b1; #1;
    total++; if (ctl !== F_R) begin bad++; $display("FAIL add_f3 got=%b exp=%b", ctl, F_R); end
    nxt(); mif.MemReady = 1'b0; #1;
    total++; if (ctl !== DEC) begin bad++; $display("FAIL add_dec got=%b exp=%b", ctl, DEC); end
    nxt(); #1;
    total++; if (ctl !== EXI_AD) begin bad++; $display("FAIL add_exi got=%b exp=%b", ctl, EXI_AD); end
    nxt(); #1;
    total++; if (ctl !== WB_RW) begin bad++; $display("FAIL add_wb got=%b exp=%b", ctl, WB_RW); end
    nxt(); #1;
    total++; if (ctl !== F_W) begin bad++; $display("FAIL add_ret got=%b exp=%b", ctl, F_W); end
    total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL add_flags got=%b exp=0000", Flags); end
  endtask

  task automatic test_sub_branch();
    Instr = SUBS; mif.MemReady = 1'b1; #1;
    total++; if (ctl !== F_R) begin bad++; $display("FAIL sub_f got=%b exp=%b", ctl, F_R); end
    nxt(); mif.MemReady = 1'b0; nxt(); ALUFlags = 4'b0110; #1;
    total++; if (ctl !== EXR_SB) begin bad++; $display("FAIL sub_exr got=%b exp=%b", ctl, EXR_SB); end
    nxt(); ALUFlags = 4'b0000; #1;
    total++; if (Flags !== 4'b0110) begin bad++; $display("FAIL sub_flags got=%b exp=0110", Flags); end
    total++; if (ctl !== WB_RW) begin bad++; $display("FAIL sub_wb got=%b exp=%b", ctl, WB_RW); end
    nxt(); Instr = BEQ; mif.MemReady = 1'b1; nxt(); mif.MemReady = 1'b0; #1;
    total++; if (ctl !== DEC) begin bad++; $display("FAIL beq_dec got=%b exp=%b", ctl, DEC); end
    nxt(); #1;
    total++; if (ctl !== BR) begin bad++; $display("FAIL beq_br got=%b exp=%b", ctl, BR); end
    total++; if (RegSrc !== 2'b01 || ImmSrc !== 2'b10) begin bad++; $display("FAIL beq_src got=%b/%b exp=01/10", RegSrc, ImmSrc); end
    nxt();
    Instr = ADDS; mif.MemReady = 1'b1; nxt(); mif.MemReady = 1'b0; nxt(); #1;
    total++; if (ctl !== EXR_AD) begin bad++; $display("FAIL adds_exr got=%b exp=%b", ctl, EXR_AD); end
    nxt(); #1;
    total++; if (Flags !== 4'b0000) begin bad++; $display("FAIL adds_flags got=%b exp=0000", Flags); end
    nxt(); Instr = BEQ; mif.MemReady = 1'b1; nxt(); mif.MemReady = 1'b0; nxt(); #1;
    total++; if (ctl !== F_W) begin bad++; $display("FAIL beq_skip got=%b exp=%b", ctl, F_W); end
  endtask

  task automatic test_ldr_str();
    Instr = LDR; mif.MemReady = 1'b1; nxt(); mif.MemReady = 1'b0; #1;
    total++; if (RegSrc !== 2'b10 || ImmSrc !== 2'b01) begin bad++; $display("FAIL ldr_src got=%b/%b exp=10/01", RegSrc, ImmSrc); end
    nxt(); #1;
    total++; if (ctl !== MADR) begin bad++; $display("FAIL ldr_adr got=%b exp=%b", ctl, MADR); end
    nxt(); #1;
    total++; if (ctl !== MRD) begin bad++; $display("FAIL ldr_rd1 got=%b exp=%b", ctl, MRD); end
    nxt(); #1;
    total++; if (ctl !== MRD) begin bad++; $display("FAIL ldr_rd2 got=%b exp=%b", ctl, MRD); end
    nxt(); mif.MemReady = 1'b1; nxt(); mif.MemReady = 1'b0; #1;
    total++; if (ctl !== MWB) begin bad++; $display("FAIL ldr_wb got=%b exp=%b", ctl, MWB); end
    nxt();
    Instr = STR; mif.MemReady = 1'b1; nxt(); mif.MemReady = 1'b0; nxt(); nxt(); #1;
    total++; if (ctl !== MWR) begin bad++; $display("FAIL str_wr1 got=%b exp=%b", ctl, MWR); end
    nxt(); mif.MemReady = 1'b1; #1;
    total++; if (ctl !== MWR) begin bad++; $display("FAIL str_wr2 got=%b exp=%b", ctl, MWR); end
    nxt(); mif.MemReady = 1'b0; #1;
    total++; if (ctl !== F_W) begin bad++; $display("FAIL str_ret got=%b exp=%b", ctl, F_W); end
  endtask

  task automatic test_cmp_ands();
    Instr = CMP; mif.MemReady = 1'b1; nxt(); mif.MemReady = 1'b0; nxt(); ALUFlags = 4'b0110; #1;
    total++; if (ctl !== EXR_SB) begin bad++; $display("FAIL cmp_exr got=%b exp=%b", ctl, EXR_SB); end
    nxt(); ALUFlags = 4'b0000; #1;
    total++; if (ctl !== IDLE) begin bad++; $display("FAIL cmp_wb got=%b exp=%b", ctl, IDLE); end
    total++; if (Flags !== 4'b0110) begin bad++; $display("FAIL cmp_flags got=%b exp=0110", Flags); end
    nxt();
    Instr = ANDS; mif.MemReady = 1'b1; nxt(); mif.MemReady = 1'b0; nxt(); ALUFlags = 4'b1011; #1;
    total++; if (ctl !== EXI_AN) begin bad++; $display("FAIL ands_exi got=%b exp=%b", ctl, EXI_AN); end
    nxt(); ALUFlags = 4'b0000; #1;
    total++; if (Flags !== 4'b1010) begin bad++; $display("FAIL ands_flags got=%b exp=1010", Flags); end
    total++; if (ctl !== WB_RW) begin bad++; $display("FAIL ands_wb got=%b exp=%b", ctl, WB_RW); end
    nxt();
  endtask

  task automatic test_timeout();
    mif.MemReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (ctl !== F_W) begin bad++; $display("FAIL to_wait%0d got=%b exp=%b", i, ctl, F_W); end
      nxt();
    end
    #1;
    total++; if (ctl !== IDLE || Fault !== 1'b1 || Busy !== 1'b0) begin bad++; $display("FAIL to_fault ctl=%b fault=%b busy=%b exp=%b/1/0", ctl, Fault, Busy, IDLE); end
    mif.MemReady = 1'b1;
    for (int i = 0; i < 3; i++) nxt();
    #1;
    total++; if (ctl !== IDLE || Fault !== 1'b1) begin bad++; $display("FAIL to_sticky ctl=%b fault=%b exp=%b/1", ctl, Fault, IDLE); end
    mif.MemReady = 1'b0; reset = 1'b0; nxt(); reset = 1'b1; #1;
    total++; if (ctl !== F_W || Fault !== 1'b0) begin bad++; $display("FAIL to_clear ctl=%b fault=%b exp=%b/0", ctl, Fault, F_W); end
  endtask

  task automatic test_ready_on_expiry();
    Instr = SUBS; mif.MemReady = 1'b0;
    for (int i = 0; i < 3; i++) nxt();
    mif.MemReady = 1'b1; #1;
    total++; if (ctl !== F_R) begin bad++; $display("FAIL exp_f4 got=%b exp=%b", ctl, F_R); end
    nxt(); mif.MemReady = 1'b0; #1;
    total++; if (ctl !== DEC || Fault !== 1'b0) begin bad++; $display("FAIL exp_dec ctl=%b fault=%b exp=%b/0", ctl, Fault, DEC); end
    nxt(); ALUFlags = 4'b0110; nxt(); ALUFlags = 4'b0000; nxt();
  endtask

  task automatic test_reset_mid_read();
    Instr = LDR; mif.MemReady = 1'b1; nxt(); mif.MemReady = 1'b0; nxt(); nxt(); #1;
    total++; if (ctl !== MRD || Flags !== 4'b0110) begin bad++; $display("FAIL mid_rd ctl=%b flags=%b exp=%b/0110", ctl, Flags, MRD); end
    reset = 1'b0; #1;
    total++; if (ctl !== IDLE) begin bad++; $display("FAIL mid_abort got=%b exp=%b", ctl, IDLE); end
    nxt(); reset = 1'b1; #1;
    total++; if (ctl !== F_W || Flags !== 4'b0000) begin bad++; $display("FAIL mid_fetch ctl=%b flags=%b exp=%b/0000", ctl, Flags, F_W); end
  endtask

  initial begin
    test_reset();
    test_fetch_add();
    test_sub_branch();
    test_ldr_str();
    test_cmp_ands();
    test_timeout();
    test_ready_on_expiry();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arm_mc_control.md
Name: arm_mc_control

Overview:
- Multicycle control unit for the ARM-subset core. It replaces the single-cycle decoder-plus-condlogic pairing with one FSM.
- Datapath shares one memory port for instruction and data, reached through a req/ready handshake with variable latency.
- Adds a registered condition-flags file, a parametrised memory wait timeout with a sticky fault, and a Busy indication for the top level.
- Sits between the multicycle datapath and the unified memory wrapper.

Parameters:
- TIMEOUT, 16: max wait cycles per memory request before FAULT; 0 disables the timeout.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- Instr  in  32  instruction register contents (valid from DECODE onward)
- ALUFlags  in  4  {N,Z,C,V} from datapath ALU, current cycle
- MemReady  in  1  memory completes the current request this cycle
- MemReq  out  1  memory request valid
- MemWrite  out  1  request is a write (only with MemReq)
- IRWrite  out  1  latch fetched word into IR
- PCWrite  out  1  update PC with Result
- RegWrite  out  1  write register file
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
- ALUSrcA  out  1  0 = Rn, 1 = PC
- ALUSrcB  out  2  00 reg, 01 ExtImm, 10 const 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR
- ImmSrc  out  2  = Instr[27:26]
- RegSrc  out  2  [0] = (Op==10), [1] = (Op==01)
- Flags  out  4  registered {N,Z,C,V}
- Busy  out  1  high in every state except FETCH waiting with MemReq low (never occurs), i.e. high except FAULT
- Fault  out  1  sticky timeout indication

Behaviour:
- Decode fields: Op = Instr[27:26], Funct = Instr[25:20], L = Instr[20], S = Instr[20], cmd = Instr[24:21].
- Reset (reset==0, async): state = FETCH, Flags = 0000, wait counter = 0, Fault = 0.
- All outputs are combinational from state plus Instr/Flags/MemReady. Inactive controls are 0.
- States and transitions:
  - FETCH: MemReq=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10. IRWrite and PCWrite assert only in the cycle MemReady=1. Then go to DECODE. Otherwise hold.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD (PC+8 into ALUOut).
    - If CondEx=0, go to FETCH; no further writes.
    - Else Op=00 and Funct[5]=0 go to EXECUTER; Op=00 and Funct[5]=1 go to EXECUTEI; Op=01 go to MEMADR; Op=10 go to BRANCH.
    - Op=11 is illegal: go to FETCH.
  - EXECUTER / EXECUTEI: ALUSrcA=0, ALUSrcB=00 or 01. ALUControl from cmd: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (SUB). Other cmd values give ADD. Then go to ALUWB.
  - Flags update in EXECUTER/EXECUTEI when S=1 or cmd=CMP:
    - ADD/SUB/CMP load all four flags from ALUFlags.
    - AND/ORR load N,Z only; C,V are held.
  - ALUWB: ResultSrc=00, RegWrite=1 unless cmd=CMP. Then go to FETCH.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. L=1 goes to MEMREAD; L=0 goes to MEMWRITE.
  - MEMREAD: MemReq=1, AdrSrc=1. Hold until MemReady, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1. Then go to FETCH.
  - MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1. Hold until MemReady, then go to FETCH.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1. Then go to FETCH.
  - FAULT: all controls 0, Fault=1, Busy=0. The only exit is reset.
- CondEx: standard ARM cond on the registered Flags, codes 0000–1110. 1111 gives CondEx=0.
- Wait counter:
  - Cleared on entry to any MemReq state and whenever MemReady=1.
  - Increments each MemReq cycle with MemReady=0.
  - If TIMEOUT≠0 and counter==TIMEOUT-1 with MemReady=0, next state is FAULT.
  - MemReady=1 in the same cycle as expiry wins: the normal transition is taken.
- Reset mid-request: MemReq drops asynchronously. No PC/IR/Reg writes are emitted that cycle.

Test Plan:
- Reset, then Instr=E2821005 (ADD R1,R2,#5), MemReady high after 2 wait cycles -> FETCH holds 3 cycles with one IRWrite/PCWrite pulse; then DECODE, EXECUTEI (ALUSrcB=01, ALUControl=000), ALUWB RegWrite=1, FETCH. Flags remain 0000.
- E0500000 (SUBS R0,R0,R0) with ALUFlags=0110 -> Flags=0110 after EXECUTER. Then 0A000002 (BEQ) -> BRANCH asserts PCWrite. With Flags=0000, BEQ returns to FETCH from DECODE with no PCWrite.
- E5923008 (LDR) -> MEMADR, MEMREAD with AdrSrc=1 held until MemReady, MEMWB ResultSrc=01 RegWrite=1. E5821004 (STR) -> MEMWRITE with MemReq=MemWrite=1, no RegWrite.
- E1520003 (CMP) -> Flags update, ALUWB RegWrite=0. E2111000 (ANDS) with ALUFlags=1011 after Flags=0110 -> Flags=1010.
- TIMEOUT=4, MemReady held low in FETCH -> FAULT after the 4th wait cycle, Fault=1, Busy=0, no MemReq. Stays in FAULT until reset=0. Separately, MemReady=1 exactly on the 4th cycle -> normal DECODE.
- Assert reset=0 mid-MEMREAD -> outputs immediately inactive. After release, FETCH with MemReq=1 and Flags=0000.
